// File: rtl/fb_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_wr_ctrl_if
// Brief    : Pixel stream, data_mem write port and frame handoff bundle.
// Revision : 1.0
// ============================================================================
interface fb_wr_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_sof;
  logic                  pix_eol;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  frame_rdy;
  logic                  rd_bank;
  logic                  frame_ack;
  logic                  sync_err;

  modport master (
    output pix_valid, pix_data, pix_sof, pix_eol, frame_ack,
    input  pix_ready, wr_en, wr_addr, wr_data, frame_rdy, rd_bank, sync_err
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, pix_eol, frame_ack,
    output pix_ready, wr_en, wr_addr, wr_data, frame_rdy, rd_bank, sync_err
  );
endinterface
`default_nettype wire

// File: rtl/fb_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fb_wr_ctrl
// Brief    : Ping-pong frame-buffer write controller feeding data_mem.
// Revision : 1.0
// ============================================================================
module fb_wr_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int H_RES      = 2,
  parameter int V_RES      = 2
) (
  input  logic        clk,
  input  logic        reset,
  fb_wr_ctrl_if.slave bus
);

  localparam int c_OW = ADDR_WIDTH - 1;
  localparam int c_XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int c_YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [c_XW-1:0] c_X_MAX   = c_XW'(H_RES - 1);
  localparam logic [c_YW-1:0] c_Y_MAX   = c_YW'(V_RES - 1);
  localparam logic [c_XW-1:0] c_X_ONE   = c_XW'(1);
  localparam logic [c_YW-1:0] c_Y_ONE   = c_YW'(1);
  localparam logic [c_OW-1:0] c_OFF_ONE = c_OW'(1);
  localparam logic            c_SOF_X_LAST = (H_RES == 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WRITE = 2'd1;
  localparam logic [1:0] c_ST_FULL  = 2'd2;

  logic [1:0]            r_state;
  logic [c_XW-1:0]       r_x;
  logic [c_YW-1:0]       r_y;
  logic [c_OW-1:0]       r_offset;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_frame_rdy;
  logic                  r_sync_err;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic            w_pix_ready;
  logic            w_accept;
  logic            w_x_last;
  logic            w_y_last;
  logic [c_XW-1:0] w_x_next;
  logic [c_YW-1:0] w_y_next;
  logic [c_XW-1:0] w_x_start;
  logic [c_YW-1:0] w_y_start;
  logic            w_cur_x_last;
  logic            w_eol_err;
  logic            w_complete;

  // Position right after a start-of-frame beat; a single-column frame moves
  // straight to the next line.
  generate
    if (H_RES == 1) begin : g_single_col
      assign w_x_start = '0;
      assign w_y_start = c_Y_ONE;
    end else begin : g_multi_col
      assign w_x_start = c_X_ONE;
      assign w_y_start = '0;
    end
  endgenerate

  assign w_pix_ready = (r_state != c_ST_FULL);
  assign w_accept    = bus.pix_valid & w_pix_ready;

  assign w_x_last = (r_x == c_X_MAX);
  assign w_y_last = (r_y == c_Y_MAX);
  assign w_x_next = w_x_last ? '0 : r_x + c_X_ONE;
  assign w_y_next = w_x_last ? r_y + c_Y_ONE : r_y;

  // A start-of-frame beat always sits at column 0, whatever the counters say.
  assign w_cur_x_last = bus.pix_sof ? c_SOF_X_LAST : w_x_last;
  assign w_eol_err    = (bus.pix_eol != w_cur_x_last);

  assign w_complete = (r_state == c_ST_WRITE) & w_accept & ~bus.pix_sof
                    & w_x_last & w_y_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_offset    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b1;
      r_frame_rdy <= 1'b0;
      r_sync_err  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_en <= 1'b0;

      // Consumer release; completion and FULL handle the ack themselves.
      if (bus.frame_ack && r_frame_rdy && !w_complete && (r_state != c_ST_FULL)) begin
        r_frame_rdy <= 1'b0;
      end

      case (r_state)
        c_ST_IDLE: begin
          if (w_accept && bus.pix_sof) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= {r_wr_bank, {c_OW{1'b0}}};
            r_wr_data <= bus.pix_data;
            r_x       <= w_x_start;
            r_y       <= w_y_start;
            r_offset  <= c_OFF_ONE;
            if (w_eol_err) begin
              r_sync_err <= 1'b1;
            end
            r_state   <= c_ST_WRITE;
          end
        end

        c_ST_WRITE: begin
          if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= bus.pix_data;
            if (bus.pix_sof) begin
              r_sync_err <= 1'b1;
              r_wr_addr  <= {r_wr_bank, {c_OW{1'b0}}};
              r_x        <= w_x_start;
              r_y        <= w_y_start;
              r_offset   <= c_OFF_ONE;
            end else begin
              r_wr_addr <= {r_wr_bank, r_offset};
              if (w_eol_err) begin
                r_sync_err <= 1'b1;
              end
              if (w_x_last && w_y_last) begin
                r_x      <= '0;
                r_y      <= '0;
                r_offset <= '0;
                if (!r_frame_rdy || bus.frame_ack) begin
                  r_rd_bank   <= r_wr_bank;
                  r_frame_rdy <= 1'b1;
                  r_wr_bank   <= ~r_wr_bank;
                  r_state     <= c_ST_IDLE;
                end else begin
                  r_state <= c_ST_FULL;
                end
              end else begin
                r_x      <= w_x_next;
                r_y      <= w_y_next;
                r_offset <= r_offset + c_OFF_ONE;
              end
            end
          end
        end

        c_ST_FULL: begin
          // Both banks hold frames; swap once the reader lets go of its bank.
          if (bus.frame_ack) begin
            r_rd_bank <= r_wr_bank;
            r_wr_bank <= ~r_wr_bank;
            r_state   <= c_ST_IDLE;
          end
        end

        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pix_ready = w_pix_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.frame_rdy = r_frame_rdy;
  assign bus.rd_bank   = r_rd_bank;
  assign bus.sync_err  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_fb_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_wr_ctrl
// Brief    : Vector table plus write scoreboard for fb_wr_ctrl.
// Revision : 1.0
// ============================================================================
module tb_fb_wr_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fb_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fb_wr_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .H_RES(2), .V_RES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          ack;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic          e_rdy;
    logic          e_frdy;
    logic          e_rdb;
    logic          e_err;
  } vec_t;

  vec_t              tv[$];
  logic [AW+DW-1:0]  sb[$];
  logic [AW+DW-1:0]  mon_exp;
  int                total = 0;
  int                bad   = 0;

  function automatic vec_t mk(bit v, logic [DW-1:0] d, bit sof, bit eol, bit ack,
                              bit e_wr, int e_addr, bit e_rdy, bit e_frdy,
                              bit e_rdb, bit e_err);
    vec_t t;
    t.v = v; t.d = d; t.sof = sof; t.eol = eol; t.ack = ack;
    t.e_wr = e_wr; t.e_addr = AW'(e_addr); t.e_rdy = e_rdy;
    t.e_frdy = e_frdy; t.e_rdb = e_rdb; t.e_err = e_err;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        mon_exp = sb.pop_front();
        check("wr_addr_data", {bus.wr_addr, bus.wr_data}, mon_exp);
      end
    end
  end

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    bus.pix_valid = t.v;
    bus.pix_data  = t.d;
    bus.pix_sof   = t.sof;
    bus.pix_eol   = t.eol;
    bus.frame_ack = t.ack;
    if (t.e_wr) sb.push_back({t.e_addr, t.d});
    @(posedge clk);
    #1;
    check($sformatf("v%0d wr_en", idx),     bus.wr_en,     t.e_wr);
    check($sformatf("v%0d pix_ready", idx), bus.pix_ready, t.e_rdy);
    check($sformatf("v%0d frame_rdy", idx), bus.frame_rdy, t.e_frdy);
    check($sformatf("v%0d rd_bank", idx),   bus.rd_bank,   t.e_rdb);
    check($sformatf("v%0d sync_err", idx),  bus.sync_err,  t.e_err);
  endtask

  initial begin
    reset         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_sof   = 1'b0;
    bus.pix_eol   = 1'b0;
    bus.frame_ack = 1'b0;

    //           v  data   sof eol ack  wr adr rdy frdy rdb err
    tv.push_back(mk(1, 'h0009, 0, 0, 0,  0, 0,  1, 0, 1, 0));
    tv.push_back(mk(1, 'h0011, 1, 0, 0,  1, 0,  1, 0, 1, 0));
    tv.push_back(mk(1, 'h0022, 0, 1, 0,  1, 1,  1, 0, 1, 0));
    tv.push_back(mk(1, 'h0033, 0, 0, 0,  1, 2,  1, 0, 1, 0));
    tv.push_back(mk(1, 'h0044, 0, 1, 0,  1, 3,  1, 1, 0, 0));
    tv.push_back(mk(1, 'h0055, 1, 0, 0,  1, 4,  1, 1, 0, 0));
    tv.push_back(mk(1, 'h0066, 0, 1, 0,  1, 5,  1, 1, 0, 0));
    tv.push_back(mk(1, 'h0077, 0, 0, 0,  1, 6,  1, 1, 0, 0));
    tv.push_back(mk(1, 'h0088, 0, 1, 0,  1, 7,  0, 1, 0, 0));
    tv.push_back(mk(1, 'h00EE, 0, 0, 0,  0, 0,  0, 1, 0, 0));
    tv.push_back(mk(0, 'h0000, 0, 0, 1,  0, 0,  1, 1, 1, 0));
    tv.push_back(mk(1, 'h0011, 1, 0, 0,  1, 0,  1, 1, 1, 0));
    tv.push_back(mk(1, 'h0022, 0, 1, 0,  1, 1,  1, 1, 1, 0));
    tv.push_back(mk(1, 'h0033, 0, 0, 0,  1, 2,  1, 1, 1, 0));
    tv.push_back(mk(1, 'h0044, 0, 1, 1,  1, 3,  1, 1, 0, 0));
    tv.push_back(mk(0, 'h0000, 0, 0, 1,  0, 0,  1, 0, 0, 0));
    tv.push_back(mk(0, 'h0000, 0, 0, 1,  0, 0,  1, 0, 0, 0));
    tv.push_back(mk(1, 'h00AA, 0, 0, 0,  0, 0,  1, 0, 0, 0));
    tv.push_back(mk(1, 'h0011, 1, 0, 0,  1, 4,  1, 0, 0, 0));
    tv.push_back(mk(1, 'h0022, 0, 1, 0,  1, 5,  1, 0, 0, 0));
    tv.push_back(mk(1, 'h0099, 1, 0, 0,  1, 4,  1, 0, 0, 1));
    tv.push_back(mk(1, 'h0012, 0, 1, 0,  1, 5,  1, 0, 0, 1));
    tv.push_back(mk(1, 'h0013, 0, 0, 0,  1, 6,  1, 0, 0, 1));
    tv.push_back(mk(1, 'h0014, 0, 1, 0,  1, 7,  1, 1, 1, 1));
    tv.push_back(mk(1, 'h0031, 1, 0, 0,  1, 0,  1, 1, 1, 1));

    repeat (2) @(posedge clk);
    #1;
    check("rst pix_ready", bus.pix_ready, 1);
    check("rst wr_en",     bus.wr_en,     0);
    check("rst wr_addr",   bus.wr_addr,   0);
    check("rst wr_data",   bus.wr_data,   0);
    check("rst frame_rdy", bus.frame_rdy, 0);
    check("rst rd_bank",   bus.rd_bank,   1);
    check("rst sync_err",  bus.sync_err,  0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

    // Reset lands while a write strobe is live; that write is abandoned.
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_data  = 16'h0032;
    bus.pix_sof   = 1'b0;
    bus.pix_eol   = 1'b1;
    bus.frame_ack = 1'b0;
    @(posedge clk);
    #1;
    check("pre-rst wr_en",   bus.wr_en,   1);
    check("pre-rst wr_addr", bus.wr_addr, 1);
    #1;
    reset = 1'b0;
    #1;
    check("async wr_en",     bus.wr_en,     0);
    check("async wr_addr",   bus.wr_addr,   0);
    check("async frame_rdy", bus.frame_rdy, 0);
    check("async sync_err",  bus.sync_err,  0);
    check("async pix_ready", bus.pix_ready, 1);
    check("async rd_bank",   bus.rd_bank,   1);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    apply(mk(1, 'h0009, 0, 0, 0,  0, 0,  1, 0, 1, 0), 100);
    apply(mk(1, 'h0011, 1, 1, 0,  1, 0,  1, 0, 1, 1), 101);
    apply(mk(0, 'h0000, 0, 0, 0,  0, 0,  1, 0, 1, 1), 102);

    repeat (3) @(negedge clk);
    check("sb drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
